// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates two writeback sources onto one register-file write port and tracks pending writes per register.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   a_valid/a_rd/a_data/a_ready        ALU writeback request (one-entry buffer)
//   b_valid/b_rd/b_data/b_ready        load-unit writeback request (one-entry buffer)
//   mark_valid/mark_rd/mark_ready      issue-stage pending-write mark
//   rs1/rs2 -> busy1/busy2             combinational hazard query
//   w/wd/write_control                 registered register-file write port
module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int DW = 64,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [AW-1:0] a_rd,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_rd,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          mark_valid,
  input  logic [AW-1:0] mark_rd,
  output logic          mark_ready,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          busy1,
  output logic          busy2,
  output logic [AW-1:0] w,
  output logic [DW-1:0] wd,
  output logic          write_control
);
  logic          a_v, b_v, a_older, rr_a;
  logic [AW-1:0] a_rd_q, b_rd_q, g_rd;
  logic [DW-1:0] a_d, b_d, g_data;
  logic [1:0]    pend [NREG];
  logic          grant_a, grant_b, a_acc, b_acc, mark_acc, do_wr;

  // Same destination must retire in arrival order; otherwise alternate via rr_a.
  always_comb begin
    grant_a = a_v & (!b_v | ((a_rd_q == b_rd_q) ? a_older : rr_a));
    grant_b = b_v & !grant_a;
    g_rd    = grant_a ? a_rd_q : b_rd_q;
    g_data  = grant_a ? a_d : b_d;
    do_wr   = (grant_a | grant_b) & (g_rd != '0);
  end

  assign a_ready    = !a_v | grant_a;
  assign b_ready    = !b_v | grant_b;
  assign a_acc      = a_valid & a_ready;
  assign b_acc      = b_valid & b_ready;
  assign mark_ready = (pend[mark_rd] != 2'd3) | (mark_rd == '0);
  assign mark_acc   = mark_valid & mark_ready & (mark_rd != '0);
  assign busy1      = pend[rs1] != 2'd0;
  assign busy2      = pend[rs2] != 2'd0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_v           <= 1'b0;
      b_v           <= 1'b0;
      a_rd_q        <= '0;
      b_rd_q        <= '0;
      a_d           <= '0;
      b_d           <= '0;
      a_older       <= 1'b0;
      rr_a          <= 1'b1;
      w             <= '0;
      wd            <= '0;
      write_control <= 1'b0;
    end else begin
      a_v <= a_acc | (a_v & !grant_a);
      b_v <= b_acc | (b_v & !grant_b);
      if (a_acc) begin
        a_rd_q <= a_rd;
        a_d    <= a_data;
      end
      if (b_acc) begin
        b_rd_q <= b_rd;
        b_d    <= b_data;
      end
      // A new entry is older only if the other buffer is not left holding an entry.
      a_older <= a_acc ? (b_acc | !(b_v & !grant_b)) : b_acc ? (a_v & !grant_a) : a_older;
      if (grant_a | grant_b) rr_a <= grant_b;
      write_control <= do_wr;
      if (do_wr) begin
        w  <= g_rd;
        wd <= g_data;
      end
    end

  // Decrement is suppressed at zero so a stray write cannot wrap the count.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int r = 0; r < NREG; r++) pend[r] <= 2'd0;
    else
      for (int r = 0; r < NREG; r++)
        pend[r] <= pend[r] + 2'(mark_acc && mark_rd == AW'(r))
                           - 2'(do_wr && g_rd == AW'(r) && pend[r] != 2'd0);
endmodule
